// File: rtl/result_pack_bram_pkg.sv
// -----------------------------------------------------------------------------
// result_pack_bram_pkg
// Shared definitions for the result packer: capture FSM state encoding and a
// constant log2 helper used to size address and lane-index fields.
// No ports (package).
// -----------------------------------------------------------------------------
package result_pack_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration time for parameter sizing.
  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pack_sdp_ram.sv
// -----------------------------------------------------------------------------
// pack_sdp_ram
// Simple dual-port RAM: one write port fed by the packer, one registered
// read-first read port for the PS. Contents are not reset; only the read
// data register is.
// Ports:
//   i_clk, i_rstn        clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata write port
//   i_re/i_raddr         read enable and address
//   o_rdata              registered read data, holds when i_re=0
// -----------------------------------------------------------------------------
module pack_sdp_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Non-blocking write above means a same-edge read returns the old word.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/result_pack_bram.sv
// -----------------------------------------------------------------------------
// result_pack_bram
// Packs narrow PORT_B_WIDTH samples from a valid/ready stream into
// PORT_A_WIDTH words (lane 0 in the LSBs) and commits them to a wide BRAM
// that the PS reads through a read-only port.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   start                     pulse: arm a new capture at address 0
//   s_valid/s_data/s_last     sample stream in, s_ready handshake out
//   done                      capture finished (s_last committed or full)
//   overflow                  buffer filled before s_last
//   word_count                wide words committed in this capture
//   ena/addra/douta           PS read port, 1-cycle latency
// -----------------------------------------------------------------------------
module result_pack_bram
  import result_pack_bram_pkg::*;
#(
  parameter int PORT_B_WIDTH = 8,
  parameter int PORT_B_DEPTH = 256,
  parameter int PORT_A_WIDTH = 32,
  parameter int IN_WORD_DATA = PORT_A_WIDTH / PORT_B_WIDTH,
  parameter int PORT_A_DEPTH = PORT_B_DEPTH / IN_WORD_DATA,
  parameter int PORT_A_ADDR  = log2_ceil(PORT_A_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [PORT_B_WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    done,
  output logic                    overflow,
  output logic [PORT_A_ADDR:0]    word_count,
  input  logic                    ena,
  input  logic [PORT_A_ADDR-1:0]  addra,
  output logic [PORT_A_WIDTH-1:0] douta
);

  localparam int                     LANE_W    = log2_ceil(IN_WORD_DATA);
  localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(IN_WORD_DATA - 1);
  localparam logic [PORT_A_ADDR-1:0] LAST_ADDR = PORT_A_ADDR'(PORT_A_DEPTH - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LANE_W-1:0]       r_lane;
  logic [PORT_A_WIDTH-1:0] r_pack;
  logic [PORT_A_ADDR-1:0]  r_wr_addr;
  logic [PORT_A_ADDR:0]    r_word_count;
  logic                    r_done;
  logic                    r_overflow;
  // Commit stage: a completed word waits here one cycle, so the pack
  // register is free to take lane 0 of the next word without stalling.
  logic                    r_cm_vld;
  logic                    r_cm_final;
  logic                    r_cm_ovf;
  logic [PORT_A_WIDTH-1:0] r_cm_data;

  logic                    w_final_pend;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_word_end;
  logic [PORT_A_WIDTH-1:0] w_pack_ins;

  // Once the word that ends the capture is pending, no further sample may
  // be taken: it would have nowhere to go.
  assign w_final_pend = r_cm_vld & r_cm_final;
  assign w_ready      = (r_state == ST_FILL) & ~start & ~w_final_pend;
  assign w_accept     = s_valid & w_ready;
  assign w_word_end   = w_accept & ((r_lane == LAST_LANE) | s_last);

  always_comb begin
    w_pack_ins = r_pack;
    w_pack_ins[int'(r_lane) * PORT_B_WIDTH +: PORT_B_WIDTH] = s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_FILL;
      ST_FILL: begin
        if (start)             w_state_nxt = ST_FILL;
        else if (w_final_pend) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (start) w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane       <= '0;
      r_pack       <= '0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_cm_vld     <= 1'b0;
      r_cm_final   <= 1'b0;
      r_cm_ovf     <= 1'b0;
    end else if (start) begin
      // Restart discards any partial pack and any pending commit.
      r_lane       <= '0;
      r_pack       <= '0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_cm_vld     <= 1'b0;
    end else begin
      r_cm_vld <= w_word_end;
      if (w_word_end) begin
        r_cm_final <= s_last | (r_wr_addr == LAST_ADDR);
        r_cm_ovf   <= ~s_last & (r_wr_addr == LAST_ADDR);
      end
      if (w_accept) begin
        if (w_word_end) begin
          r_lane <= '0;
          r_pack <= '0;
        end else begin
          r_lane <= r_lane + 1'b1;
          r_pack <= w_pack_ins;
        end
      end
      if (r_cm_vld) begin
        r_word_count <= r_word_count + 1'b1;
        if (r_wr_addr != LAST_ADDR) r_wr_addr <= r_wr_addr + 1'b1;
        if (r_cm_final) begin
          r_done     <= 1'b1;
          r_overflow <= r_cm_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_word_end) r_cm_data <= w_pack_ins;
  end

  pack_sdp_ram #(
    .WIDTH  (PORT_A_WIDTH),
    .DEPTH  (PORT_A_DEPTH),
    .ADDR_W (PORT_A_ADDR)
  ) u_ram (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_we    (r_cm_vld & ~start),
    .i_waddr (r_wr_addr),
    .i_wdata (r_cm_data),
    .i_re    (ena),
    .i_raddr (addra),
    .o_rdata (douta)
  );

  assign s_ready    = w_ready;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign word_count = r_word_count;

endmodule
